z80_bus_responder: RTL



---
 rtl/z80_bus_pkg.sv | 42 ++++
 rtl/z80_cycle_decode.sv | 38 +++
 rtl/z80_bus_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types for the tv80s bus responder and future bus peripherals:
// FSM states, decoded cycle kinds and the packed bus-strobe bundle.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        MEMRD = 3'd0,
        MEMWR = 3'd1,
        IORD  = 3'd2,
        IOWR  = 3'd3,
        INTA  = 3'd4,
        NONE  = 3'd5
    } cycle_e;

    // Bit order matches the {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} concatenation.
    typedef struct packed {
        logic m1_n;
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic rfsh_n;
    } bus_strobe_t;

    localparam logic [7:0] INTA_DEFAULT = 8'hFF;

    // I/O and interrupt-acknowledge cycles live in the I/O page and use the I/O wait count.
    function automatic logic is_io_kind(input cycle_e k);
        return (k == IORD) || (k == IOWR) || (k == INTA);
    endfunction

    function automatic logic is_write_kind(input cycle_e k);
        return (k == MEMWR) || (k == IOWR);
    endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// Combinational tv80s strobe decode: classifies the current bus strobes into a
// cycle kind and forms the effective RAM address ({IO_PAGE, A[7:0]} for I/O).
module z80_cycle_decode
    import z80_bus_pkg::*;
#(
    parameter logic [7:0] IO_PAGE = 8'h10
) (
    input  logic [5:0]  strb_i,
    input  logic [15:0] addr_i,
    output logic [2:0]  kind_o,
    output logic [15:0] eff_o
);

    bus_strobe_t s;
    cycle_e      kind;

    assign s = bus_strobe_t'(strb_i);

    // Refresh is never a transfer; INTA is recognised before plain I/O because both pull iorq_n.
    always_comb begin
        kind = NONE;
        if (!s.rfsh_n) begin
            kind = NONE;
        end else if (!s.iorq_n && !s.m1_n) begin
            kind = INTA;
        end else if (!s.iorq_n) begin
            if (!s.rd_n)      kind = IORD;
            else if (!s.wr_n) kind = IOWR;
        end else if (!s.mreq_n) begin
            if (!s.rd_n)      kind = MEMRD;
            else if (!s.wr_n) kind = MEMWR;
        end
    end

    assign kind_o = kind;
    assign eff_o  = is_io_kind(kind) ? {IO_PAGE, addr_i[7:0]} : addr_i;

endmodule

// File: rtl/z80_bus_responder.sv
// Synchronous 64 KiB memory / I/O target for the tv80s bus with programmable
// wait states, an interrupt-acknowledge vector and a committed-write counter.
// Optional write protect below ROM_TOP is compiled in with Z80_RESP_ROMPROT_EN.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int         MEM_WAIT = 0,
    parameter int         IO_WAIT  = 1,
    parameter logic [7:0] IO_PAGE  = 8'h10,
    parameter logic [7:0] INTA_VEC = INTA_DEFAULT,
    parameter logic [15:0] ROM_TOP = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    input  logic        bd_we,
    input  logic [15:0] bd_addr,
    input  logic [7:0]  bd_wdata,
    output logic [7:0]  bd_rdata,
    output logic [15:0] wr_count,
    output logic [15:0] last_wr_addr
);

    localparam logic [2:0] MEM_N = 3'(MEM_WAIT);
    localparam logic [2:0] IO_N  = 3'(IO_WAIT);

    logic [7:0]  mem [0:65535];

    logic [2:0]  kind_raw;
    cycle_e      kind_dec;
    logic [15:0] eff_dec;
    logic        bus_idle;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    cycle_e      kind_q, kind_d;
    logic [15:0] eff_q, eff_d;
    logic [2:0]  wait_sel;

    logic        wr_ok;
    logic        do_rd, do_wr, do_inta;
    logic        wait_n_o;

    logic [7:0]  di_q;
    logic [15:0] wr_count_q;
    logic [15:0] last_wr_addr_q;

    z80_cycle_decode #(
        .IO_PAGE (IO_PAGE)
    ) u_decode (
        .strb_i (bus_strobe_t'({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n})),
        .addr_i (A),
        .kind_o (kind_raw),
        .eff_o  (eff_dec)
    );

    assign kind_dec = cycle_e'(kind_raw);
    assign bus_idle = mreq_n && iorq_n && rd_n && wr_n;

`ifdef Z80_RESP_ROMPROT_EN
    assign wr_ok = (eff_q >= ROM_TOP);
`else
    // Without write protect every address is writable; ROM_TOP has no effect.
    assign wr_ok = 1'b1 | (eff_q < ROM_TOP);
`endif

    // State register: FSM state, wait counter and the cycle latched at its start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            kind_q  <= NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
        eff_q <= eff_d;
    end

    // Next-state logic: start on a decoded strobe, count waits, access once, hold until release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        eff_d    = eff_q;
        wait_sel = is_io_kind(kind_dec) ? IO_N : MEM_N;
        case (state_q)
            IDLE: begin
                if (kind_dec != NONE) begin
                    kind_d = kind_dec;
                    eff_d  = eff_dec;
                    if (wait_sel != 3'd0) begin
                        state_d = WAIT;
                        cnt_d   = wait_sel;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (bus_idle) begin
                    // CPU dropped the cycle (e.g. CPU reset): abandon it without a commit.
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_d == 3'd0) state_d = ACCESS;
                end
            end
            ACCESS: state_d = HOLD;
            HOLD:   if (bus_idle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: wait_n is low for exactly the cycles spent in WAIT; ACCESS fires one operation.
    always_comb begin
        wait_n_o = (state_q != WAIT);
        do_rd    = 1'b0;
        do_wr    = 1'b0;
        do_inta  = 1'b0;
        if (state_q == ACCESS && !reset) begin
            do_rd   = (kind_q == MEMRD) || (kind_q == IORD);
            do_wr   = is_write_kind(kind_q) && wr_ok;
            do_inta = (kind_q == INTA);
        end
    end

    // Read-data and write-tracking registers updated by the single ACCESS operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            di_q           <= 8'hFF;
            wr_count_q     <= 16'h0000;
            last_wr_addr_q <= 16'h0000;
        end else begin
            if (do_rd)   di_q <= mem[eff_q];
            if (do_inta) di_q <= INTA_VEC;
            if (do_wr) begin
                wr_count_q     <= wr_count_q + 16'h0001;
                last_wr_addr_q <= eff_q;
            end
        end
    end

    // RAM: backdoor write first so a same-address bus write in the same clock wins.
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
        if (do_wr) mem[eff_q]   <= dout;
    end

    assign bd_rdata     = mem[bd_addr];
    assign di           = di_q;
    assign wait_n       = wait_n_o;
    assign wr_count     = wr_count_q;
    assign last_wr_addr = last_wr_addr_q;

endmodule
